// File: rtl/dpram_port2_dma.sv
// Port-2 transfer engine for the shared 256x16 dual-port RAM: streams a block of
// words into RAM or out of RAM, started by a one-cycle command.
module dpram_port2_dma #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic              busy,
    output logic              done
);

    // state     | meaning
    // IDLE      | waiting for start
    // WR_STREAM | accepting s_data, one RAM write per handshake
    // RD_ISSUE  | ram_rd high, RAM returns data at the next edge
    // RD_OUT    | holding m_data/m_valid until m_ready
    // DONE      | one-cycle done pulse
    typedef enum logic [2:0] {
        IDLE,
        WR_STREAM,
        RD_ISSUE,
        RD_OUT,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              go;
    logic              wr_hs;
    logic              rd_hs;
    logic              rd_capture;
    logic              last_word;

    assign last_word = (remaining == LEN_W'(1));

    always_comb begin
        state_next = state;
        go         = 1'b0;
        wr_hs      = 1'b0;
        rd_hs      = 1'b0;
        rd_capture = 1'b0;
        case (state)
            IDLE: begin
                // abort in IDLE suppresses a simultaneous start
                if (start && !abort) begin
                    go = 1'b1;
                    if (length == '0)
                        state_next = DONE;
                    else if (dir)
                        state_next = RD_ISSUE;
                    else
                        state_next = WR_STREAM;
                end
            end
            WR_STREAM: begin
                if (abort)
                    state_next = IDLE;
                else if (s_valid) begin
                    wr_hs = 1'b1;
                    if (last_word)
                        state_next = DONE;
                end
            end
            RD_ISSUE: begin
                if (abort)
                    state_next = IDLE;
                else begin
                    rd_capture = 1'b1;
                    state_next = RD_OUT;
                end
            end
            RD_OUT: begin
                if (abort)
                    state_next = IDLE;
                else if (m_ready) begin
                    rd_hs      = 1'b1;
                    state_next = last_word ? DONE : RD_ISSUE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
        end else begin
            state  <= state_next;
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;
            if (go) begin
                cur_addr  <= base_addr;
                remaining <= length;
                if (dir && length != '0) begin
                    ram_rd   <= 1'b1;
                    ram_addr <= base_addr;
                end
            end
            if (wr_hs) begin
                ram_wr    <= 1'b1;
                ram_addr  <= cur_addr;
                ram_din   <= s_data;
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (rd_capture) begin
                m_data  <= ram_dout;
                m_valid <= 1'b1;
            end
            if (rd_hs) begin
                m_valid   <= 1'b0;
                remaining <= remaining - 1'b1;
                if (!last_word) begin
                    ram_rd   <= 1'b1;
                    ram_addr <= cur_addr + 1'b1;
                    cur_addr <= cur_addr + 1'b1;
                end
            end
            if (abort && state != IDLE)
                m_valid <= 1'b0;
        end
    end

    assign s_ready = (state == WR_STREAM);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_dpram_port2_dma.sv
// Scoreboard bench for dpram_port2_dma: a negedge RAM stand-in on port 2, a
// reference memory image, and a monitor that checks every RAM access and output word.
module tb_dpram_port2_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, dir, abort, s_valid, m_ready;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic [15:0] s_data;
    logic        s_ready, m_valid, ram_rd, ram_wr, busy, done;
    logic [15:0] m_data, ram_din, ram_dout;
    logic [7:0]  ram_addr;

    dpram_port2_dma dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .base_addr(base_addr),
        .length(length), .abort(abort), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM stand-in: acts on the falling edge, read has priority
    logic [15:0] mem [256];
    always @(negedge clk) begin
        if (ram_rd)      ram_dout <= mem[ram_addr];
        else if (ram_wr) mem[ram_addr] <= ram_din;
    end

    logic [15:0] ref_mem [256];
    logic [7:0]  exp_wa[$];
    logic [15:0] exp_wd[$];
    logic [7:0]  exp_ra[$];
    logic [15:0] exp_rd[$];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int exp_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops expectations whenever the DUT presents a RAM access or an output word
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rd && ram_wr) chk("rd_wr_overlap", 32'(1), 32'(0));
            if (ram_wr) begin
                if (exp_wa.size() == 0) chk("unexpected_write", 32'(ram_addr), 32'hFFFF_FFFF);
                else begin
                    chk("wr_addr", 32'(ram_addr), 32'(exp_wa.pop_front()));
                    chk("wr_data", 32'(ram_din), 32'(exp_wd.pop_front()));
                end
            end
            if (ram_rd) begin
                if (exp_ra.size() == 0) chk("unexpected_read", 32'(ram_addr), 32'hFFFF_FFFF);
                else chk("rd_addr", 32'(ram_addr), 32'(exp_ra.pop_front()));
            end
            if (m_valid && m_ready) begin
                if (exp_rd.size() == 0) chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                else chk("m_data", 32'(m_data), 32'(exp_rd.pop_front()));
            end
            if (done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic d, input logic [7:0] b, input logic [8:0] len);
        start = 1'b1; dir = d; base_addr = b; length = len;
        tick();
        start = 1'b0;
    endtask

    // gapmode 1: one idle cycle before every word; 0: random 0..2 idle cycles
    task automatic do_write(input logic [7:0] b, input logic [8:0] len, input int gapmode);
        logic [15:0] d;
        logic [7:0]  a;
        int gap;
        start_cmd(1'b0, b, len);
        for (int i = 0; i < int'(len); i++) begin
            d = 16'($urandom);
            if (gapmode == 1 && i < 4) d = 16'hA001 + 16'(i);
            a = 8'(b + 8'(i));
            exp_wa.push_back(a); exp_wd.push_back(d); ref_mem[a] = d;
            gap = (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
            s_valid = 1'b0;
            repeat (gap) begin
                // start while busy must be ignored
                start = 1'b1; dir = 1'b1; base_addr = 8'h55; length = 9'd3;
                tick();
                start = 1'b0;
            end
            s_valid = 1'b1; s_data = d;
            chk("s_ready", 32'(s_ready), 32'(1));
            tick();
        end
        s_valid = 1'b0;
        chk("wr_done", 32'(done), 32'(1));
        chk("wr_s_ready_drop", 32'(s_ready), 32'(0));
        exp_done++;
        tick();
        chk("wr_idle_busy", 32'(busy), 32'(0));
        chk("wr_idle_done", 32'(done), 32'(0));
    endtask

    task automatic do_read(input logic [7:0] b, input logic [8:0] len,
                           input int stall_word, input int stall_n);
        logic [7:0]  a;
        logic [15:0] cap;
        int n;
        for (int i = 0; i < int'(len); i++) begin
            a = 8'(b + 8'(i));
            exp_ra.push_back(a); exp_rd.push_back(ref_mem[a]);
        end
        m_ready = 1'b1;
        start_cmd(1'b1, b, len);
        chk("rd_issue", 32'(ram_rd), 32'(1));
        chk("rd_base", 32'(ram_addr), 32'(b));
        for (int i = 0; i < int'(len); i++) begin
            n = 0;
            while (!m_valid && n < 20) begin tick(); n++; end
            chk("m_valid_wait", 32'(m_valid), 32'(1));
            chk("valid_latency", 32'(n), 32'(1));
            if (i == stall_word) begin
                m_ready = 1'b0;
                cap = m_data;
                repeat (stall_n) begin
                    tick();
                    chk("stall_valid", 32'(m_valid), 32'(1));
                    chk("stall_data", 32'(m_data), 32'(cap));
                end
                m_ready = 1'b1;
            end
            tick();
        end
        chk("rd_done", 32'(done), 32'(1));
        exp_done++;
        m_ready = 1'b0;
        tick();
        chk("rd_idle_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0; s_valid = 1'b0;
        m_ready = 1'b0; base_addr = '0; length = '0; s_data = '0;
        #3;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_outs", 32'({s_ready, m_valid, ram_rd, ram_wr, done}), 32'(0));
        chk("rst_addr", 32'(ram_addr), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_write(8'h10, 9'd4, 1);
        do_read(8'h10, 9'd4, -1, 0);

        do_write(8'hFE, 9'd4, 0);
        do_read(8'hFE, 9'd4, 1, 5);

        // length 0: done right after the start edge, back to IDLE on the next
        start_cmd(1'b0, 8'h20, 9'd0);
        chk("len0_done", 32'(done), 32'(1));
        chk("len0_busy", 32'(busy), 32'(1));
        exp_done++;
        start = 1'b1; dir = 1'b0; base_addr = 8'h33; length = 9'd2;
        tick();
        start = 1'b0;
        chk("len0_idle", 32'({busy, done}), 32'(0));
        tick();
        chk("len0_ignored", 32'(busy), 32'(0));

        // abort after 2 of 6 write handshakes
        start_cmd(1'b0, 8'h40, 9'd6);
        for (int i = 0; i < 2; i++) begin
            s_data = 16'($urandom);
            exp_wa.push_back(8'(8'h40 + 8'(i))); exp_wd.push_back(s_data);
            ref_mem[8'(8'h40 + 8'(i))] = s_data;
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 32'({busy, s_ready, done}), 32'(0));
        repeat (3) tick();
        do_read(8'h40, 9'd2, -1, 0);

        // abort and start together in IDLE
        abort = 1'b1;
        start_cmd(1'b0, 8'h60, 9'd3);
        abort = 1'b0;
        chk("abort_start", 32'(busy), 32'(0));

        // long write wraps the address space and overwrites earlier words
        do_write(8'hF0, 9'd258, 0);
        do_read(8'hF0, 9'd4, -1, 0);

        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(8'($urandom), 9'($urandom_range(1, 8)), 0);
            else
                do_read(8'($urandom), 9'($urandom_range(1, 8)),
                        int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        // async reset mid-read with m_valid high
        exp_ra.push_back(8'h10);
        m_ready = 1'b0;
        start_cmd(1'b1, 8'h10, 9'd4);
        tick();
        chk("pre_rst_valid", 32'(m_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'({busy, done, m_valid, ram_rd, ram_wr, s_ready}), 32'(0));
        chk("rst_mid_data", 32'(m_data), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("post_rst_idle", 32'({busy, done}), 32'(0));
        end
        do_read(8'h10, 9'd2, 0, 2);

        repeat (2) tick();
        chk("wr_queue_empty", 32'(exp_wa.size()), 32'(0));
        chk("ra_queue_empty", 32'(exp_ra.size()), 32'(0));
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'(0));
        chk("done_count", 32'(done_seen), 32'(exp_done));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
